// File: rtl/td4_run_ctrl.sv
// Run/load sequencer for the TD4 CPU: loads program memory with the CPU held in reset,
// then issues per-instruction clock enables in free-run or single-step mode with a PC breakpoint.
module td4_run_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic              wr_strobe,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              run,
  input  logic              step,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [DIV_W-1:0]  div,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              cpu_en,
  output logic              cpu_rst_n,
  output logic [1:0]        state,
  output logic              halted,
  output logic [DIV_W-1:0]  insn_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_BRK  = 2'b11
  } state_t;

  state_t            state_r;
  logic              step_q_r;
  logic              exempt_r;
  logic [ADDR_W-1:0] load_addr_r;
  logic [DIV_W-1:0]  div_cnt_r;

  logic              step_edge_s;
  logic              load_entry_s;
  logic              issue_s;
  logic              bp_hit_s;
  logic [DIV_W-1:0]  cnt_sat_s;

  assign state = state_r;

  // Decode of edges, issue points and the saturating counter increment.
  always_comb begin
    step_edge_s  = step & ~step_q_r;
    load_entry_s = load_req & (state_r != ST_LOAD);
    // >= rather than == keeps the divider bounded if div shrinks mid-run
    issue_s      = (div_cnt_r >= div);
    bp_hit_s     = bp_en & (pc == bp_addr) & ~exempt_r;
    if (insn_cnt == {DIV_W{1'b1}}) begin
      cnt_sat_s = insn_cnt;
    end else begin
      cnt_sat_s = insn_cnt + DIV_W'(1);
    end
  end

  // Sequencer state machine with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      step_q_r    <= 1'b0;
      exempt_r    <= 1'b0;
      load_addr_r <= ADDR_W'(0);
      div_cnt_r   <= DIV_W'(0);
      mem_addr    <= ADDR_W'(0);
      mem_wdata   <= DATA_W'(0);
      mem_we      <= 1'b0;
      cpu_en      <= 1'b0;
      cpu_rst_n   <= 1'b0;
      halted      <= 1'b0;
      insn_cnt    <= DIV_W'(0);
    end else begin
      step_q_r <= step;
      mem_we   <= 1'b0;
      cpu_en   <= 1'b0;
      if (load_entry_s) begin
        // load_req wins from every non-LOAD state
        state_r     <= ST_LOAD;
        cpu_rst_n   <= 1'b0;
        halted      <= 1'b0;
        insn_cnt    <= DIV_W'(0);
        load_addr_r <= ADDR_W'(0);
        div_cnt_r   <= DIV_W'(0);
      end else begin
        case (state_r)
          ST_IDLE: begin
            cpu_rst_n <= 1'b1;
            halted    <= 1'b0;
            if (run) begin
              state_r   <= ST_RUN;
              div_cnt_r <= DIV_W'(0);
              exempt_r  <= 1'b1;
            end else if (step_edge_s) begin
              cpu_en   <= 1'b1;
              insn_cnt <= cnt_sat_s;
            end
          end
          ST_LOAD: begin
            cpu_rst_n <= 1'b0;
            if (wr_strobe) begin
              mem_we      <= 1'b1;
              mem_addr    <= load_addr_r;
              mem_wdata   <= wr_data;
              load_addr_r <= load_addr_r + ADDR_W'(1);
            end
            if (!load_req) begin
              state_r   <= ST_IDLE;
              cpu_rst_n <= 1'b1;
            end
          end
          ST_RUN: begin
            if (!run) begin
              state_r   <= ST_IDLE;
              div_cnt_r <= DIV_W'(0);
            end else if (issue_s) begin
              div_cnt_r <= DIV_W'(0);
              exempt_r  <= 1'b0;
              if (bp_hit_s) begin
                state_r <= ST_BRK;
                halted  <= 1'b1;
              end else begin
                cpu_en   <= 1'b1;
                insn_cnt <= cnt_sat_s;
              end
            end else begin
              div_cnt_r <= div_cnt_r + DIV_W'(1);
            end
          end
          ST_BRK: begin
            if (step_edge_s) begin
              cpu_en   <= 1'b1;
              insn_cnt <= cnt_sat_s;
              state_r  <= ST_IDLE;
              halted   <= 1'b0;
            end else if (!run) begin
              state_r <= ST_IDLE;
              halted  <= 1'b0;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            halted  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_td4_run_ctrl.sv
// Directed self-checking bench for td4_run_ctrl: load, free-run, breakpoint, step, saturation, async reset.
module tb_td4_run_ctrl;

  logic       clk;
  logic       rst_n;
  logic       load_req;
  logic       wr_strobe;
  logic [7:0] wr_data;
  logic       run;
  logic       step;
  logic       bp_en;
  logic [3:0] bp_addr;
  logic [7:0] div;
  logic [3:0] pc;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       cpu_en;
  logic       cpu_rst_n;
  logic [1:0] state;
  logic       halted;
  logic [7:0] insn_cnt;

  int checks = 0;
  int errors = 0;
  logic we_seen;

  td4_run_ctrl #(.ADDR_W(4), .DATA_W(8), .DIV_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .wr_strobe(wr_strobe),
    .wr_data(wr_data), .run(run), .step(step), .bp_en(bp_en), .bp_addr(bp_addr),
    .div(div), .pc(pc), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .cpu_en(cpu_en), .cpu_rst_n(cpu_rst_n), .state(state), .halted(halted),
    .insn_cnt(insn_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge mem_we) we_seen = 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state), 32'h0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'h0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 32'h0);
    chk({tag, "_we"}, 32'(mem_we), 32'h0);
    chk({tag, "_cpu_en"}, 32'(cpu_en), 32'h0);
    chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'h0);
    chk({tag, "_halted"}, 32'(halted), 32'h0);
    chk({tag, "_insn_cnt"}, 32'(insn_cnt), 32'h0);
  endtask

  task automatic load_word(input logic [7:0] data, input logic [3:0] exp_addr);
    wr_strobe = 1'b1;
    wr_data   = data;
    tick();
    wr_strobe = 1'b0;
    chk("load_we", 32'(mem_we), 32'h1);
    chk("load_addr", 32'(mem_addr), 32'(exp_addr));
    chk("load_wdata", 32'(mem_wdata), 32'(data));
    chk("load_cpu_rst_n", 32'(cpu_rst_n), 32'h0);
    tick();
    chk("load_we_drop", 32'(mem_we), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; load_req = 1'b0; wr_strobe = 1'b0; wr_data = 8'h00;
    run = 1'b0; step = 1'b0; bp_en = 1'b0; bp_addr = 4'h0; div = 8'h00; pc = 4'h0;
    tick();
    tick();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick();
    chk("rst_release_cpu_rst_n", 32'(cpu_rst_n), 32'h1);
    chk("rst_release_state", 32'(state), 32'h0);

    // three-word load
    load_req = 1'b1;
    tick();
    chk("load_state", 32'(state), 32'h1);
    chk("load_entry_cpu_rst_n", 32'(cpu_rst_n), 32'h0);
    load_word(8'h3A, 4'h0);
    load_word(8'h51, 4'h1);
    load_word(8'hB7, 4'h2);
    load_req = 1'b0;
    tick();
    chk("load_exit_state", 32'(state), 32'h0);
    chk("load_exit_cpu_rst_n", 32'(cpu_rst_n), 32'h1);

    // 17 words: address wraps, last strobe coincides with load_req drop
    load_req = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      load_word(8'h40 + 8'(i), 4'(i));
    end
    wr_strobe = 1'b1;
    wr_data   = 8'h50;
    load_req  = 1'b0;
    tick();
    wr_strobe = 1'b0;
    chk("wrap_we", 32'(mem_we), 32'h1);
    chk("wrap_addr", 32'(mem_addr), 32'h0);
    chk("wrap_wdata", 32'(mem_wdata), 32'h50);
    chk("wrap_state", 32'(state), 32'h0);
    chk("wrap_cpu_rst_n", 32'(cpu_rst_n), 32'h1);

    // strobe outside LOAD is ignored
    wr_strobe = 1'b1;
    wr_data   = 8'hEE;
    tick();
    wr_strobe = 1'b0;
    chk("idle_strobe_we", 32'(mem_we), 32'h0);

    // free-run with div=3: pulse every 4th clock
    div = 8'd3;
    run = 1'b1;
    tick();
    chk("run_state", 32'(state), 32'h2);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("div3_en_%0d", k), 32'(cpu_en), (k % 4 == 0) ? 32'h1 : 32'h0);
    end
    chk("div3_cnt", 32'(insn_cnt), 32'h4);
    run = 1'b0;
    tick();
    chk("run_stop_state", 32'(state), 32'h0);

    // breakpoint at 5, starting from pc=2 with div=0
    div = 8'd0; bp_en = 1'b1; bp_addr = 4'h5; pc = 4'h2;
    run = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bp_pre_en_%0d", k), 32'(cpu_en), 32'h1);
      pc = pc + 4'h1;
    end
    tick();
    chk("bp_hit_en", 32'(cpu_en), 32'h0);
    chk("bp_hit_state", 32'(state), 32'h3);
    chk("bp_hit_halted", 32'(halted), 32'h1);
    chk("bp_hit_cnt", 32'(insn_cnt), 32'h7);
    tick();
    chk("bp_hold_state", 32'(state), 32'h3);
    chk("bp_hold_en", 32'(cpu_en), 32'h0);
    step = 1'b1;
    run  = 1'b0;
    tick();
    chk("bp_step_en", 32'(cpu_en), 32'h1);
    chk("bp_step_state", 32'(state), 32'h0);
    chk("bp_step_halted", 32'(halted), 32'h0);
    chk("bp_step_cnt", 32'(insn_cnt), 32'h8);
    pc = pc + 4'h1;
    step = 1'b0;
    tick();
    chk("bp_step_once", 32'(cpu_en), 32'h0);

    // resume from the breakpoint PC: first issue is exempt, wraps back to 5
    pc  = 4'h5;
    run = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("exempt_en_%0d", k), 32'(cpu_en), 32'h1);
      pc = pc + 4'h1;
    end
    tick();
    chk("exempt_rehit_en", 32'(cpu_en), 32'h0);
    chk("exempt_rehit_state", 32'(state), 32'h3);
    chk("exempt_rehit_cnt", 32'(insn_cnt), 32'h18);
    run = 1'b0;
    tick();
    chk("brk_norun_state", 32'(state), 32'h0);
    chk("brk_norun_halted", 32'(halted), 32'h0);

    // single step in IDLE: one pulse per rising edge only
    step = 1'b1;
    tick();
    chk("idle_step_en", 32'(cpu_en), 32'h1);
    chk("idle_step_state", 32'(state), 32'h0);
    tick();
    chk("idle_step_level", 32'(cpu_en), 32'h0);
    chk("idle_step_cnt", 32'(insn_cnt), 32'h19);
    step = 1'b0;

    // counter saturation
    bp_en = 1'b0;
    run   = 1'b1;
    for (int k = 0; k < 300; k++) tick();
    chk("sat_cnt", 32'(insn_cnt), 32'hFF);
    run = 1'b0;
    tick();

    // load entry clears counter; async reset drops a pending write
    load_req = 1'b1;
    tick();
    chk("reload_cnt_clear", 32'(insn_cnt), 32'h0);
    chk("reload_state", 32'(state), 32'h1);
    we_seen   = 1'b0;
    wr_strobe = 1'b1;
    wr_data   = 8'hC3;
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    tick();
    wr_strobe = 1'b0;
    tick();
    chk("arst_no_we", 32'(we_seen), 32'h0);
    chk_reset_vals("arst_hold");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
